// File: rtl/micro_sequencer_if.sv
// Sequencer-facing signal bundle: instruction/handshake inputs, programming port
// and the control/status outputs. Widths follow the sequencer parameters.
interface micro_sequencer_if #(
    parameter int OPC_W = 5,
    parameter int SW    = 3,
    parameter int CW    = 32,
    parameter int CNT_W = 64
);
    logic                   run;
    logic [OPC_W-1:0]       opcode;
    logic                   cond;
    logic                   mem_ready;
    logic                   trap;
    logic                   prog_we;
    logic [OPC_W+SW-1:0]    prog_addr;
    logic [CW-1:0]          prog_data;
    logic                   err_clr;
    logic [CW-5:0]          ctrl;
    logic [SW-1:0]          step;
    logic                   retire;
    logic [CNT_W-1:0]       instret;
    logic                   seq_err;
    logic                   timeout_err;

    modport master (
        output run, opcode, cond, mem_ready, trap, prog_we, prog_addr, prog_data, err_clr,
        input  ctrl, step, retire, instret, seq_err, timeout_err
    );

    modport slave (
        input  run, opcode, cond, mem_ready, trap, prog_we, prog_addr, prog_data, err_clr,
        output ctrl, step, retire, instret, seq_err, timeout_err
    );
endinterface

// File: rtl/micro_sequencer.sv
// Programmable microcode sequencer: writable {opcode, step} store, per-word
// sequencing bits, stall watchdog, step-overflow flag and retired-instruction counter.
module micro_sequencer #(
    parameter int OPC_W   = 5,
    parameter int STEPS   = 8,
    parameter int CW      = 32,
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    micro_sequencer_if.slave bus
);
    localparam int SW    = $clog2(STEPS);
    localparam int DEPTH = 2 ** (OPC_W + SW);
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]   LAST_STEP = SW'(STEPS - 1);
    localparam logic [TO_W-1:0] WD_LIMIT  = TO_W'(TIMEOUT - 1);

    logic [CW-1:0]    store [DEPTH];
    logic [CW-1:0]    word;
    logic [SW-1:0]    step_q;
    logic [TO_W-1:0]  stall_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             retire_q, seq_err_q, timeout_err_q;
    logic             inc_b, rst_b, cond_b, wait_b;
    logic             adv, stalled, inc_e, rst_e, wd_fire;

    always_ff @(posedge clk) begin
        if (bus.prog_we && !bus.run)
            store[bus.prog_addr] <= bus.prog_data;
    end

    assign word    = store[{bus.opcode, step_q}];
    assign inc_b   = word[CW-1];
    assign rst_b   = word[CW-2];
    assign cond_b  = word[CW-3];
    assign wait_b  = word[CW-4];
    assign adv     = !wait_b || bus.mem_ready;
    assign stalled = !adv;
    assign inc_e   = cond_b ? bus.cond  : inc_b;
    assign rst_e   = cond_b ? !bus.cond : rst_b;
    assign wd_fire = (TIMEOUT > 0) && stalled && (stall_cnt == WD_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q        <= '0;
            stall_cnt     <= '0;
            instret_q     <= '0;
            retire_q      <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            // Clear first so a same-cycle set event below overrides it.
            if (bus.err_clr) begin
                seq_err_q     <= 1'b0;
                timeout_err_q <= 1'b0;
            end
            if (bus.run) begin
                if (bus.trap) begin
                    step_q    <= '0;
                    stall_cnt <= '0;
                end else if (wd_fire) begin
                    step_q        <= '0;
                    stall_cnt     <= '0;
                    timeout_err_q <= 1'b1;
                end else if (rst_e && adv) begin
                    step_q    <= '0;
                    stall_cnt <= '0;
                    retire_q  <= 1'b1;
                    instret_q <= instret_q + CNT_W'(1);
                end else if (inc_e && adv) begin
                    stall_cnt <= '0;
                    if (step_q == LAST_STEP) begin
                        step_q    <= '0;
                        seq_err_q <= 1'b1;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end else if (stalled) begin
                    // Saturate so a disabled watchdog never wraps the count.
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + TO_W'(1);
                end else begin
                    stall_cnt <= '0;
                end
            end
        end
    end

    assign bus.ctrl        = (bus.run && !bus.trap) ? word[CW-5:0] : '0;
    assign bus.step        = step_q;
    assign bus.retire      = retire_q;
    assign bus.instret     = instret_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboarded bench for micro_sequencer: a cycle-level reference model queues
// expected outputs per cycle; a monitor on the falling edge compares them.
module tb_micro_sequencer;
    localparam int OPC_W   = 5;
    localparam int STEPS   = 8;
    localparam int SW      = 3;
    localparam int CW      = 32;
    localparam int CNT_W   = 64;
    localparam int TIMEOUT = 3;

    localparam logic [31:0] F_INC  = 32'h8000_0000;
    localparam logic [31:0] F_RST  = 32'h4000_0000;
    localparam logic [31:0] F_COND = 32'h2000_0000;
    localparam logic [31:0] F_WAIT = 32'h1000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    micro_sequencer_if #(.OPC_W(OPC_W), .SW(SW), .CW(CW), .CNT_W(CNT_W)) bus ();

    micro_sequencer #(.OPC_W(OPC_W), .STEPS(STEPS), .CW(CW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-5:0]    ctrl;
        logic [SW-1:0]    step;
        logic             retire;
        logic [CNT_W-1:0] instret;
        logic             seq_err;
        logic             timeout_err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]      m_store [256];
    int               m_step, m_stall;
    logic [CNT_W-1:0] m_instret;
    bit               m_retire, m_se, m_te;

    // Driven values for the next cycle
    bit          d_rst_n, d_run, d_cond, d_mr, d_trap, d_we, d_eclr;
    logic [4:0]  d_opc;
    logic [7:0]  d_addr;
    logic [31:0] d_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctrl",        64'(bus.ctrl),        64'(e.ctrl));
                chk("step",        64'(bus.step),        64'(e.step));
                chk("retire",      64'(bus.retire),      64'(e.retire));
                chk("instret",     64'(bus.instret),     64'(e.instret));
                chk("seq_err",     64'(bus.seq_err),     64'(e.seq_err));
                chk("timeout_err", 64'(bus.timeout_err), 64'(e.timeout_err));
            end
        end
    end

    // One clock cycle: drive inputs, queue what the outputs must show this cycle,
    // then work out the state the upcoming rising edge should produce.
    task automatic tick();
        exp_t e;
        logic [31:0] w;
        bit inc_e, rst_e, stall;
        @(posedge clk);
        #2;
        reset_n       = d_rst_n;
        bus.run       = d_run;
        bus.opcode    = d_opc;
        bus.cond      = d_cond;
        bus.mem_ready = d_mr;
        bus.trap      = d_trap;
        bus.prog_we   = d_we;
        bus.prog_addr = d_addr;
        bus.prog_data = d_data;
        bus.err_clr   = d_eclr;
        if (!d_rst_n) begin
            m_step = 0; m_stall = 0; m_instret = '0; m_retire = 0; m_se = 0; m_te = 0;
        end
        w = m_store[int'(d_opc) * STEPS + m_step];
        e.ctrl        = (d_run && !d_trap) ? w[27:0] : '0;
        e.step        = SW'(m_step);
        e.retire      = m_retire;
        e.instret     = m_instret;
        e.seq_err     = m_se;
        e.timeout_err = m_te;
        exp_q.push_back(e);

        if (d_rst_n) begin
            stall = w[28] && !d_mr;
            inc_e = w[29] ? d_cond  : w[31];
            rst_e = w[29] ? !d_cond : w[30];
            m_retire = 0;
            if (d_eclr) begin m_se = 0; m_te = 0; end
            if (d_run) begin
                if (d_trap) begin
                    m_step = 0; m_stall = 0;
                end else if (stall && m_stall == TIMEOUT - 1) begin
                    m_step = 0; m_stall = 0; m_te = 1;
                end else if (stall) begin
                    m_stall++;
                end else if (rst_e) begin
                    m_step = 0; m_stall = 0; m_retire = 1; m_instret++;
                end else begin
                    m_stall = 0;
                    if (inc_e) begin
                        if (m_step == STEPS - 1) begin m_step = 0; m_se = 1; end
                        else m_step++;
                    end
                end
            end
        end
        if (d_we && !d_run) m_store[d_addr] = d_data;
    endtask

    task automatic quiet();
        d_trap = 0; d_we = 0; d_eclr = 0;
    endtask

    task automatic prog(input int op, input int st, input logic [31:0] data);
        quiet();
        d_run = 0; d_we = 1; d_addr = 8'(op * STEPS + st); d_data = data;
        tick();
        d_we = 0;
    endtask

    task automatic run_n(input int op, input bit c, input bit mr, input int n);
        quiet();
        d_run = 1; d_opc = 5'(op); d_cond = c; d_mr = mr;
        repeat (n) tick();
    endtask

    task automatic trap_cycle();
        quiet();
        d_run = 1; d_trap = 1;
        tick();
        d_trap = 0;
    endtask

    initial begin : driver
        d_rst_n = 0; d_run = 0; d_cond = 0; d_mr = 0; d_opc = '0;
        d_addr = '0; d_data = '0;
        quiet();
        bus.run = 0; bus.opcode = '0; bus.cond = 0; bus.mem_ready = 0; bus.trap = 0;
        bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0; bus.err_clr = 0;
        m_step = 0; m_stall = 0; m_instret = '0; m_retire = 0; m_se = 0; m_te = 0;
        for (int i = 0; i < 256; i++) m_store[i] = '0;

        repeat (2) tick();
        d_rst_n = 1;
        for (int a = 0; a < 256; a++) prog(a / STEPS, a % STEPS, $urandom);

        // Three-step instruction: INC, INC, RST
        prog(5, 0, F_INC | 32'h11);
        prog(5, 1, F_INC | 32'h22);
        prog(5, 2, F_RST | 32'h33);
        trap_cycle();
        run_n(5, 0, 0, 7);

        // Wait-on-ready inside the watchdog window
        prog(6, 0, F_INC | 32'h1);
        prog(6, 1, F_WAIT | F_INC | 32'h2);
        prog(6, 2, F_RST | 32'h3);
        trap_cycle();
        run_n(6, 0, 1, 1);
        run_n(6, 0, 0, 2);
        run_n(6, 0, 1, 3);

        // Watchdog fires, then err_clr
        prog(7, 0, F_WAIT | F_INC | 32'h7);
        trap_cycle();
        run_n(7, 0, 0, 4);
        d_eclr = 1; tick(); d_eclr = 0;
        run_n(7, 0, 0, 1);

        // Conditional branch at step 3, both directions
        for (int s = 0; s < 3; s++) prog(8, s, F_INC | 32'(s));
        prog(8, 3, F_COND | 32'h44);
        prog(8, 4, F_RST | 32'h55);
        trap_cycle();
        run_n(8, 1, 0, 6);
        run_n(8, 1, 0, 3);
        run_n(8, 0, 0, 3);

        // Step overflow, then trap mid-sequence
        for (int s = 0; s < STEPS; s++) prog(9, s, F_INC | 32'(16 * s));
        trap_cycle();
        run_n(9, 0, 0, 10);
        trap_cycle();
        run_n(9, 0, 0, 2);
        d_eclr = 1; tick(); d_eclr = 0;

        // Async reset mid-stall, and a write attempted while running
        trap_cycle();
        run_n(6, 0, 1, 1);
        run_n(6, 0, 0, 1);
        d_rst_n = 0; tick(); d_rst_n = 1;
        d_run = 1; d_opc = 5'd5; d_we = 1; d_addr = 8'(5 * STEPS); d_data = F_RST | 32'hABC;
        tick();
        d_we = 0;
        trap_cycle();
        run_n(5, 0, 0, 4);

        // Randomized traffic across all rows
        for (int i = 0; i < 600; i++) begin
            d_run  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) d_opc = 5'($urandom);
            d_cond = 1'($urandom);
            d_mr   = ($urandom_range(0, 2) != 0);
            d_trap = ($urandom_range(0, 15) == 0);
            d_we   = ($urandom_range(0, 3) == 0);
            d_addr = 8'($urandom);
            d_data = $urandom;
            d_eclr = d_run && ($urandom_range(0, 7) == 0);
            tick();
        end
        quiet();
        d_run = 0;
        tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised, programmable microcode sequencer; successor to the fixed-table control unit.
- Holds a writable microcode store indexed by {opcode, step}.
- Drives a control word each cycle and advances the step counter using per-word sequencing bits: increment, reset, conditional select and wait-on-ready.
- Adds a stall watchdog, step-overflow detection and a retired-instruction counter; sits between the instruction register and the datapath.

Parameters:
- OPC_W, 5, opcode index width; the store has 2**OPC_W opcode rows.
- STEPS, 8, micro-steps per opcode (power of 2, >=2). SW = clog2(STEPS).
- CW, 32, stored microword width. Bits [CW-1:CW-4] are sequencer-owned; bits [CW-5:0] drive ctrl.
- CNT_W, 64, instret counter width.
- TIMEOUT, 255, maximum consecutive stalled cycles before the watchdog fires. 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  sequencer enable; 0 = halted/programming mode
- opcode  in  OPC_W  current opcode row; driven by the instruction register, held stable by the user
- cond  in  1  branch condition, used when the COND bit is set
- mem_ready  in  1  completion strobe, used when the WAIT bit is set
- trap  in  1  abort current instruction
- prog_we  in  1  microcode write strobe
- prog_addr  in  OPC_W+SW  write address {opcode, step}
- prog_data  in  CW  microword to write
- err_clr  in  1  clears the sticky error flags
- ctrl  out  CW-4  datapath control lines
- step  out  SW  current micro-step
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  retired instruction count
- seq_err  out  1  sticky: step overflow
- timeout_err  out  1  sticky: watchdog fired

Behaviour:
- Microword fields of W = store[{opcode, step}]:
  - CW-1 INC
  - CW-2 RST
  - CW-3 COND
  - CW-4 WAIT
- Store read is combinational.
- ctrl = W[CW-5:0] when run && !trap, else 0.
- Reset (reset_n low, asynchronous):
  - step=0, instret=0, retire=0, seq_err=0, timeout_err=0, stall counter=0.
  - Store contents are not reset.
- Programming:
  - When prog_we && !run, the store entry at prog_addr takes prog_data at the clock edge.
  - prog_we while run=1 is ignored and the store is unchanged.
- Advance: adv = !WAIT || mem_ready.
- Effective control:
  - If COND=1: inc_e = cond, rst_e = !cond.
  - Otherwise: inc_e = INC, rst_e = RST.
- Next state at each rising edge, in priority order:
  1. !run: hold everything; retire=0.
  2. trap: step<=0, stall counter<=0, no retire.
  3. Watchdog: WAIT && !mem_ready && stall counter==TIMEOUT-1 (TIMEOUT>0): step<=0, timeout_err<=1, stall counter<=0.
  4. rst_e && adv: step<=0, retire<=1, instret<=instret+1 (wraps modulo 2**CNT_W). RST takes precedence over INC when both are set.
  5. inc_e && adv:
     - step==STEPS-1: step<=0, seq_err<=1, no retire.
     - Otherwise step<=step+1.
  6. Otherwise step holds. This covers a stall (WAIT && !mem_ready) and a word with no sequencing bits.
- Stall counter:
  - Increments each run cycle with WAIT && !mem_ready.
  - Clears on any advance, on trap, and on watchdog fire.
- retire is registered and high for exactly one cycle per completed instruction.
- err_clr clears seq_err and timeout_err. If a set event occurs in the same cycle as err_clr, the set wins.
- Latency:
  - ctrl reflects the new step in the same cycle the step register updates.
  - instret is visible one cycle after the retiring edge, together with retire.

Test Plan:
- Program row 5: steps 0-2 = INC|ctrl 0x11, INC|ctrl 0x22, RST|ctrl 0x33. Run with opcode=5 -> ctrl 0x11, 0x22, 0x33, then 0x11 again; retire pulses once per 3 cycles; instret=2 after 6 cycles.
- Step 1 = WAIT|INC; hold mem_ready=0 for 4 cycles, then 1 -> step stays 1 for 4 cycles, reaches 2 on the 5th edge, no errors.
- Set TIMEOUT=3; WAIT word with mem_ready held 0 -> after 3 stalled cycles step=0 and timeout_err=1; err_clr clears it next cycle.
- COND word at step 3: cond=1 -> step 4; cond=0 -> step 0 with retire=1 and instret+1.
- All STEPS words INC-only -> step wraps from 7 to 0 with seq_err=1 and no retire; assert trap mid-sequence -> ctrl=0 that cycle and step=0 next edge.
- Assert reset_n low asynchronously mid-stall -> step, instret and errors 0 immediately; a prog_we while run=1 leaves the store unchanged (read back via ctrl).
